// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that reuses one 4-bit carry-lookahead slice per clock,
// LSB nibble first, with valid/ready handshakes on both the operand and result sides.

module adder4 (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin,
   output logic [3:0] Sum,
   output logic       Cout,
   output logic       Pout,
   output logic       Gout
);
   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;

   always_comb begin
      p    = A ^ B;
      g    = A & B;
      c    = '0;
      c[0] = Cin;
      for (int unsigned i = 0; i < 4; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      Sum  = p ^ c[3:0];
      Cout = c[4];
      Pout = &p;
      Gout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   end
endmodule

module nibble_serial_adder #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Pout,
   output logic             Gout,
   output logic             busy
);
   localparam int unsigned NIB = WIDTH / 4;
   localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             cout_q, cout_d, pout_q, pout_d, gout_q, gout_d;
   logic             pacc_q, pacc_d, gacc_q, gacc_d;

   logic [3:0] sl_a, sl_b, sl_sum;
   logic       sl_cout, sl_p, sl_g, pacc_upd, gacc_upd;

   // Constant-index mux over nibbles keeps the part-selects width-safe for every WIDTH.
   always_comb begin
      sl_a = '0;
      sl_b = '0;
      for (int unsigned n = 0; n < NIB; n++) begin
         if (idx_q == CW'(n)) begin
            sl_a = a_q[4*n +: 4];
            sl_b = b_q[4*n +: 4];
         end
      end
   end

   adder4 u_slice (
      .A    (sl_a),
      .B    (sl_b),
      .Cin  (carry_q),
      .Sum  (sl_sum),
      .Cout (sl_cout),
      .Pout (sl_p),
      .Gout (sl_g)
   );

   assign in_ready  = (state_q == IDLE) & ~rst;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign Sum       = sum_q;
   assign Cout      = cout_q;
   assign Pout      = pout_q;
   assign Gout      = gout_q;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      pout_d   = pout_q;
      gout_d   = gout_q;
      pacc_d   = pacc_q;
      gacc_d   = gacc_q;
      pacc_upd = pacc_q & sl_p;
      gacc_upd = sl_g | (sl_p & gacc_q);
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               a_d     = A;
               b_d     = B;
               carry_d = Cin;
               idx_d   = '0;
               pacc_d  = 1'b1;
               gacc_d  = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int unsigned n = 0; n < NIB; n++) begin
               if (idx_q == CW'(n)) sum_d[4*n +: 4] = sl_sum;
            end
            carry_d = sl_cout;
            pacc_d  = pacc_upd;
            gacc_d  = gacc_upd;
            if (idx_q == LAST) begin
               cout_d  = sl_cout;
               pout_d  = pacc_upd;
               gout_d  = gacc_upd;
               state_d = DONE;
            end else begin
               idx_d = idx_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         pout_q  <= 1'b0;
         gout_q  <= 1'b0;
         pacc_q  <= 1'b0;
         gacc_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         pout_q  <= pout_d;
         gout_q  <= gout_d;
         pacc_q  <= pacc_d;
         gacc_q  <= gacc_d;
      end
   end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and model-checked bench for nibble_serial_adder at WIDTH=64, 8 and 4.

module tb_nibble_serial_adder;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, Cin, out_valid, out_ready, Cout, Pout, Gout, busy;
   logic [63:0] A, B, Sum;

   logic       w8_in_valid, w8_in_ready, w8_Cin, w8_out_valid, w8_out_ready;
   logic       w8_Cout, w8_Pout, w8_Gout, w8_busy;
   logic [7:0] w8_A, w8_B, w8_Sum;

   logic       w4_in_valid, w4_in_ready, w4_Cin, w4_out_valid, w4_out_ready;
   logic       w4_Cout, w4_Pout, w4_Gout, w4_busy;
   logic [3:0] w4_A, w4_B, w4_Sum;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.WIDTH(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .Cin(Cin),
      .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum), .Cout(Cout), .Pout(Pout),
      .Gout(Gout), .busy(busy)
   );

   nibble_serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(w8_in_valid), .in_ready(w8_in_ready), .A(w8_A), .B(w8_B),
      .Cin(w8_Cin), .out_valid(w8_out_valid), .out_ready(w8_out_ready), .Sum(w8_Sum),
      .Cout(w8_Cout), .Pout(w8_Pout), .Gout(w8_Gout), .busy(w8_busy)
   );

   nibble_serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(w4_in_valid), .in_ready(w4_in_ready), .A(w4_A), .B(w4_B),
      .Cin(w4_Cin), .out_valid(w4_out_valid), .out_ready(w4_out_ready), .Sum(w4_Sum),
      .Cout(w4_Cout), .Pout(w4_Pout), .Gout(w4_Gout), .busy(w4_busy)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: {Cout,Sum} from plain addition, Pout = AND of A^B, Gout = carry out with Cin=0.
   function automatic logic [66:0] ref64(input logic [63:0] a, input logic [63:0] b, input logic c);
      logic [64:0] s;
      logic [64:0] s0;
      s  = {1'b0, a} + {1'b0, b} + {64'd0, c};
      s0 = {1'b0, a} + {1'b0, b};
      return {s, &(a ^ b), s0[64]};
   endfunction

   // Inputs are scrambled while the operation runs and in_valid toggles while the result is held.
   task automatic op64(input string tag, input logic [63:0] a, input logic [63:0] b, input logic c,
                       input int unsigned hold, input logic [66:0] exp);
      int unsigned n;
      logic [66:0] got;
      A = a; B = b; Cin = c; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      check({tag, "_accept"}, 128'(n < 50), 128'd1);
      @(negedge clk);
      n = 0;
      while (!out_valid && n < 100) begin
         A = {$urandom, $urandom}; B = {$urandom, $urandom};
         Cin = 1'($urandom_range(0, 1)); in_valid = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      check({tag, "_lat"}, 128'(n), 128'd16);
      got = {Cout, Sum, Pout, Gout};
      check({tag, "_res"}, 128'(got), 128'(exp));
      for (int unsigned i = 0; i < hold; i++) begin
         A = {$urandom, $urandom}; B = ~A; in_valid = ~in_valid;
         @(negedge clk);
         check({tag, "_hold"}, 128'({out_valid, in_ready, Cout, Sum, Pout, Gout}), 128'({2'b10, got}));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b0;
      check({tag, "_handoff"}, 128'({out_valid, in_ready, busy}), 128'(3'b010));
   endtask

   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [10:0] exp);
      int unsigned n;
      w8_A = a; w8_B = b; w8_Cin = c; w8_in_valid = 1'b1;
      @(negedge clk);
      w8_in_valid = 1'b0; w8_A = ~a; w8_B = ~b; w8_Cin = ~c;
      n = 0;
      while (!w8_out_valid && n < 50) begin @(negedge clk); n++; end
      check({tag, "_lat"}, 128'(n), 128'd2);
      check({tag, "_res"}, 128'({w8_Cout, w8_Sum, w8_Pout, w8_Gout}), 128'(exp));
      w8_out_ready = 1'b1;
      @(negedge clk);
      w8_out_ready = 1'b0;
   endtask

   task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b, input logic c,
                      input logic [6:0] exp);
      int unsigned n;
      w4_A = a; w4_B = b; w4_Cin = c; w4_in_valid = 1'b1;
      @(negedge clk);
      w4_in_valid = 1'b0; w4_A = ~a; w4_B = ~b; w4_Cin = ~c;
      n = 0;
      while (!w4_out_valid && n < 50) begin @(negedge clk); n++; end
      check({tag, "_lat"}, 128'(n), 128'd1);
      check({tag, "_res"}, 128'({w4_Cout, w4_Sum, w4_Pout, w4_Gout}), 128'(exp));
      w4_out_ready = 1'b1;
      @(negedge clk);
      w4_out_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] ra, rb;
      logic        rc;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0;
      w8_in_valid = 1'b0; w8_out_ready = 1'b0; w8_A = '0; w8_B = '0; w8_Cin = 1'b0;
      w4_in_valid = 1'b0; w4_out_ready = 1'b0; w4_A = '0; w4_B = '0; w4_Cin = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", 128'({out_valid, in_ready, busy, Cout, Pout, Gout, Sum}), 128'd0);
      rst = 1'b0;
      @(negedge clk);
      check("reset_release", 128'({in_ready, out_valid, busy}), 128'(3'b100));

      // T1, T2 with hand-computed {Cout, Sum, Pout, Gout}
      op64("t1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, {1'b1, 64'd0, 1'b0, 1'b1});
      op64("t2_cin1", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 0,
           {1'b1, 64'd0, 1'b1, 1'b0});
      op64("t2_cin0", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 0,
           {1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0});
      // T3 backpressure
      op64("t3", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 5,
           {1'b0, 64'h1234_5678_9ABC_DF01, 1'b0, 1'b0});

      // T4 reset while idx=7
      A = 64'hFFFF_0000_FFFF_0000; B = 64'h0F0F_0F0F_0F0F_0F0F; Cin = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      check("t4_running", 128'({busy, out_valid}), 128'(2'b10));
      rst = 1'b1;
      @(negedge clk);
      check("t4_abort", 128'({out_valid, busy, in_ready, Sum}), 128'd0);
      rst = 1'b0;
      @(negedge clk);
      check("t4_ready", 128'({in_ready, out_valid}), 128'(2'b10));
      op64("t4_after", 64'd1, 64'd2, 1'b0, 0, {1'b0, 64'd3, 1'b0, 1'b0});

      // T5/T6 model-checked pairs with throttled out_ready
      for (int unsigned k = 0; k < 150; k++) begin
         ra = {$urandom, $urandom};
         rb = (k % 5 == 0) ? ~ra : {$urandom, $urandom};
         rc = 1'($urandom_range(0, 1));
         op64("rand", ra, rb, rc, $urandom_range(0, 3), ref64(ra, rb, rc));
      end

      op8("w8_t1", 8'hFF, 8'h01, 1'b0, {1'b1, 8'h00, 1'b0, 1'b1});
      op8("w8_t2_cin1", 8'hAA, 8'h55, 1'b1, {1'b1, 8'h00, 1'b1, 1'b0});
      op8("w8_t2_cin0", 8'hAA, 8'h55, 1'b0, {1'b0, 8'hFF, 1'b1, 1'b0});
      op4("w4_t1", 4'hF, 4'h1, 1'b0, {1'b1, 4'h0, 1'b0, 1'b1});
      op4("w4_t2_cin1", 4'hA, 4'h5, 1'b1, {1'b1, 4'h0, 1'b1, 1'b0});
      op4("w4_t2_cin0", 4'hA, 4'h5, 1'b0, {1'b0, 4'hF, 1'b1, 1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
